rle_decode_scheduler: RTL
=========================

// Module: rle_decode_scheduler
// PURPOSE
//  Shares one RLE decoder among NUM_CH codeword queues; each queue has a stack-style
//  empty/read interface. Grants the decoder to one channel per frame, in round-robin order.
//  Steers that channel's codewords into the decoder and returns its serial bits.
//  Resets the decoder's output polarity between frames.
//  Sits between the per-channel codeword stacks and the single decoder instance.
// PARAMETERS
//  NUM_CH   2     number of requesting channels, legal range 2..4
//  CW_W     8     codeword width; must match the decoder
//  TERM_CW  8'h20 frame terminator codeword (run length 0)
// PORTS
//  sclk           in   1         clock; all logic on its rising edge
//  rst_n          in   1         asynchronous, active-low reset
//  ch_empty       in   NUM_CH    per-channel stack empty
//  ch_word        in   NUM_CH*8  per-channel head codeword; ch c occupies [8c+7:8c]
//  ch_read        out  NUM_CH    per-channel pop strobe
//  ch_bit         out  NUM_CH    per-channel decoded serial bit
//  ch_bit_valid   out  NUM_CH    per-channel bit qualifier
//  dec_rst        out  1         decoder reset (active high)
//  dec_stack_empty out 1         empty flag presented to the decoder
//  dec_code_word  out  8         codeword presented to the decoder
//  dec_read       in   1         decoder pop strobe (combinational in the decoder's load state)
//  dec_ser_out    in   1         decoder serial output
//  dec_bit_valid  in   1         decoder bit qualifier
//  grant_id       out  2         index of the granted channel
//  busy           out  1         a frame is in progress (state DRST, RUN or FLUSH)
//  frame_done     out  1         one-cycle pulse when the terminator is consumed
//  bad_code       out  1         sticky: a codeword < TERM_CW was popped
// BEHAVIOUR
//  Reset values: dec_rst=1, dec_stack_empty=1, grant_id=0, busy=0, frame_done=0, bad_code=0.
//   ch_read, ch_bit and ch_bit_valid are 0. The round-robin pointer holds NUM_CH-1, so ch0 wins first.
//  FSM states: IDLE, DRST, RUN, FLUSH.
//   IDLE: dec_rst=0. If any ch_empty[c]=0, register the winner into grant_id -> DRST.
//   DRST (1 cycle): dec_rst=1 so the decoder TFF clears and every frame starts at the same polarity.
//     dec_stack_empty=1 -> RUN.
//   RUN: dec_stack_empty=ch_empty[g]; dec_code_word=ch_word[g]; ch_read[g]=dec_read (combinational).
//     ch_bit[g]=dec_ser_out; ch_bit_valid[g]=dec_bit_valid. All other channels are held at 0.
//     When dec_read=1 and dec_code_word==TERM_CW: frame_done pulses next cycle -> FLUSH.
//   FLUSH (1 cycle): dec_stack_empty=1 while the decoder returns to idle; the pointer is updated to g.
//     Then -> IDLE, or straight to DRST if another request is pending. Gap between frames: 2 cycles min.
//  Round robin: search starts at pointer+1 mod NUM_CH; the first channel with ch_empty=0 wins.
//  Grant is held for the whole frame; no preemption.
//  Granted channel goes empty mid-frame: the decoder stalls idle and the grant is kept.
//   Other requesters wait, with no timeout.
//  Codeword < TERM_CW: still passed to the decoder (wraps to a long run) and sets bad_code.
//   bad_code clears only on reset.
//  Requests arriving during DRST, RUN or FLUSH are only considered at the next arbitration.
//  rst_n low mid-frame: all state returns to reset values immediately. Frame bits are dropped.
//   The queue pop already performed is not undone.
//  grant_id is meaningful only while busy=1.
// CONFIGURATION
//  RLE_SCHED_PRIO_EN defined: arbitration uses strict priority, lowest index wins.
//   The pointer is unused, and ch0 can starve the other channels.
//  RLE_SCHED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  T1 reset: hold rst_n=0 -> dec_rst=1, dec_stack_empty=1, all ch_* outputs 0.
//   Release rst_n -> dec_rst=0 after 1 clock.
//  T2 single frame: ch0 pushes 21,23,20 -> DRST, then RUN.
//   Expect ch_bit[0] to show 1 bit of 0 then 3 bits of 1 (bit_valid high), frame_done once, ch_read[0] pulsed 3x.
//  T3 round robin, NUM_CH=2: both channels hold frames {22,20} x3 -> grant order 0,1,0,1,0,1.
//   No bit_valid ever appears on the ungranted channel.
//  T4 empty mid-frame: ch1 raises empty after 21 with no terminator -> grant stays on ch1.
//   ch0 is not granted until ch1 supplies 20.
//  T5 bad code: ch0 pops 1F -> bad_code=1 and stays 1 until rst_n.
//  T6 PRIO_EN build: ch0 and ch1 request continuously -> only ch0 is granted.
//   Default build under the same stimulus alternates grants.

Source files
------------

// File: rtl/rle_decode_scheduler_if.sv
// Channel-stack and decoder buses of the RLE decode scheduler.
// slave = scheduler side; master = stacks + decoder side.
interface rle_decode_scheduler_if #(
    parameter int NUM_CH = 2,
    parameter int CW_W   = 8
);
    logic [NUM_CH-1:0]      ch_empty;
    logic [NUM_CH*CW_W-1:0] ch_word;
    logic [NUM_CH-1:0]      ch_read;
    logic [NUM_CH-1:0]      ch_bit;
    logic [NUM_CH-1:0]      ch_bit_valid;
    logic                   dec_rst;
    logic                   dec_stack_empty;
    logic [CW_W-1:0]        dec_code_word;
    logic                   dec_read;
    logic                   dec_ser_out;
    logic                   dec_bit_valid;

    modport slave (
        input  ch_empty, ch_word, dec_read, dec_ser_out, dec_bit_valid,
        output ch_read, ch_bit, ch_bit_valid, dec_rst, dec_stack_empty, dec_code_word
    );

    modport master (
        output ch_empty, ch_word, dec_read, dec_ser_out, dec_bit_valid,
        input  ch_read, ch_bit, ch_bit_valid, dec_rst, dec_stack_empty, dec_code_word
    );
endinterface

// File: rtl/rle_decode_scheduler.sv
// Shares one RLE decoder among NUM_CH codeword stacks, one channel per frame.
// Build option RLE_SCHED_PRIO_EN: strict priority (lowest index) instead of round-robin.
//
// state | meaning
// IDLE  | decoder released, waiting for any non-empty channel
// DRST  | one cycle of decoder reset so every frame starts at the same polarity
// RUN   | granted channel wired to the decoder until its terminator is popped
// FLUSH | one cycle with the decoder starved while it returns to load; pointer advances
module rle_decode_scheduler #(
    parameter int              NUM_CH  = 2,
    parameter int              CW_W    = 8,
    parameter logic [CW_W-1:0] TERM_CW = CW_W'(32'h20)
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    rle_decode_scheduler_if.slave bus,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 bad_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRST  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            dec_rst_q, dec_rst_d;
    logic            frame_done_q, frame_done_d;
    logic            bad_code_q, bad_code_d;

    logic            req_any;
    logic [1:0]      win;
    logic            g_empty;
    logic [CW_W-1:0] g_word;

`ifdef RLE_SCHED_PRIO_EN
    always_comb begin
        req_any = 1'b0;
        win     = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!bus.ch_empty[c]) begin
                req_any = 1'b1;
                win     = 2'(c);
            end
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] arb_base;

    // In FLUSH the pointer is about to become the current grant, so arbitrate from it already.
    always_comb begin
        arb_base = (state_q == S_FLUSH) ? grant_q : ptr_q;
        ptr_d    = (state_q == S_FLUSH) ? grant_q : ptr_q;
    end

    // Second pass (channels above the base) overrides the wrapped pass, lowest index wins in each.
    always_comb begin
        req_any = 1'b0;
        win     = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!bus.ch_empty[c] && (2'(c) <= arb_base)) begin
                req_any = 1'b1;
                win     = 2'(c);
            end
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!bus.ch_empty[c] && (2'(c) > arb_base)) begin
                req_any = 1'b1;
                win     = 2'(c);
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'(NUM_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        g_empty = 1'b1;
        g_word  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (2'(c) == grant_q) begin
                g_empty = bus.ch_empty[c];
                g_word  = bus.ch_word[c*CW_W +: CW_W];
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        frame_done_d         = 1'b0;
        bad_code_d           = bad_code_q;
        bus.dec_stack_empty  = 1'b1;
        bus.dec_code_word    = '0;
        bus.ch_read          = '0;
        bus.ch_bit           = '0;
        bus.ch_bit_valid     = '0;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    grant_d = win;
                    state_d = S_DRST;
                end
            end
            S_DRST: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                bus.dec_stack_empty = g_empty;
                bus.dec_code_word   = g_word;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (2'(c) == grant_q) begin
                        bus.ch_read[c]      = bus.dec_read;
                        bus.ch_bit[c]       = bus.dec_ser_out;
                        bus.ch_bit_valid[c] = bus.dec_bit_valid;
                    end
                end
                // Short codewords still go through; the decoder wraps them to a long run.
                if (bus.dec_read && (g_word < TERM_CW)) begin
                    bad_code_d = 1'b1;
                end
                if (bus.dec_read && (g_word == TERM_CW)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (req_any) begin
                    grant_d = win;
                    state_d = S_DRST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dec_rst_d = (state_d == S_DRST);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            dec_rst_q    <= 1'b1;
            frame_done_q <= 1'b0;
            bad_code_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            dec_rst_q    <= dec_rst_d;
            frame_done_q <= frame_done_d;
            bad_code_q   <= bad_code_d;
        end
    end

    assign bus.dec_rst = dec_rst_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_q;
    assign bad_code    = bad_code_q;

endmodule
